fc_scheduler: RTL and testbench

- Sequences the binarized fully-connected layer between the conv2/maxpool stage and the top controller's class-compare logic.
- Consumes one binarized maxpool feature bit per maxpool_valid pulse and fetches that feature's weight word from the FC weight ROM.
- Accumulates signed XNOR-popcount scores for all classes in parallel, then presents them with a level valid for the controller's argmax sweep.

---
 rtl/fc_scheduler.sv | 108 ++++++++++
 tb/tb_fc_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fc_scheduler.sv
// Binarized fully-connected layer sequencer: fetches one weight word per feature and
// accumulates XNOR-popcount scores for all classes. Optional macro FC_BIAS_EN preloads per-class bias.
module fc_scheduler #(
  parameter int FEAT_N    = 144,
  parameter int NUM_CLASS = 10,
  parameter int ACC_W     = 10,
  parameter int ADDR_W    = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic                       maxpool_valid,
  input  logic                       maxpool_bit,
  output logic                       w_rd,
  output logic [ADDR_W-1:0]          w_addr,
  input  logic [NUM_CLASS-1:0]       w_data,
  input  logic [NUM_CLASS*ACC_W-1:0] fc_bias,
  output logic [NUM_CLASS*ACC_W-1:0] fc_result,
  output logic                       fc_result_valid,
  output logic                       busy
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        feat_cnt;
  logic                    s1_valid;
  logic                    s1_bit;
  logic signed [ACC_W-1:0] acc [NUM_CLASS];
  logic                    accept;

`ifndef FC_BIAS_EN
  logic unused_bias;
  assign unused_bias = ^fc_bias;
`endif

  // start always wins over a feature presented in the same cycle
  assign accept = (state == ACCUM) && maxpool_valid && !start
                  && (feat_cnt < CNT_W'(FEAT_N));
  assign w_rd   = accept;
  assign w_addr = feat_cnt[ADDR_W-1:0];
  assign busy   = (state == ACCUM) || (state == DRAIN);

  always_comb begin
    fc_result = '0;
    for (int k = 0; k < NUM_CLASS; k++)
      fc_result[k*ACC_W +: ACC_W] = acc[k];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      feat_cnt        <= '0;
      s1_valid        <= 1'b0;
      s1_bit          <= 1'b0;
      fc_result_valid <= 1'b0;
      for (int k = 0; k < NUM_CLASS; k++)
        acc[k] <= '0;
    end else if (start) begin
      // restart from any state; an in-flight stage-1 feature is dropped
      state           <= ACCUM;
      feat_cnt        <= '0;
      s1_valid        <= 1'b0;
      fc_result_valid <= 1'b0;
      for (int k = 0; k < NUM_CLASS; k++) begin
`ifdef FC_BIAS_EN
        acc[k] <= fc_bias[k*ACC_W +: ACC_W];
`else
        acc[k] <= '0;
`endif
      end
    end else begin
      s1_valid <= accept;
      if (accept)
        s1_bit <= maxpool_bit;

      // w_data belongs to the feature captured in stage 1
      if (s1_valid) begin
        for (int k = 0; k < NUM_CLASS; k++) begin
          if (s1_bit ~^ w_data[k]) begin
            if (acc[k] != ACC_MAX) acc[k] <= acc[k] + ACC_ONE;
          end else begin
            if (acc[k] != ACC_MIN) acc[k] <= acc[k] - ACC_ONE;
          end
        end
      end

      case (state)
        ACCUM: begin
          if (accept) begin
            feat_cnt <= feat_cnt + CNT_W'(1);
            if (feat_cnt == CNT_W'(FEAT_N - 1))
              state <= DRAIN;
          end
        end
        DRAIN:   state <= DONE;
        DONE:    fc_result_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_scheduler.sv
// Directed bench for fc_scheduler with a one-cycle-latency weight ROM model.
`timescale 1ns/1ps
module tb_fc_scheduler;

  localparam int FEAT_N    = 144;
  localparam int NUM_CLASS = 10;
  localparam int ACC_W     = 10;
  localparam int ADDR_W    = 8;
`ifdef FC_BIAS_EN
  localparam int BIAS0 = 5;
`else
  localparam int BIAS0 = 0;
`endif

  logic                       clk = 1'b0;
  logic                       rstn;
  logic                       start;
  logic                       maxpool_valid;
  logic                       maxpool_bit;
  logic                       w_rd;
  logic [ADDR_W-1:0]          w_addr;
  logic [NUM_CLASS-1:0]       w_data = '0;
  logic [NUM_CLASS*ACC_W-1:0] fc_bias;
  logic [NUM_CLASS*ACC_W-1:0] fc_result;
  logic                       fc_result_valid;
  logic                       busy;

  logic [NUM_CLASS-1:0] weightWord = '1;
  int wrdCount = 0;
  int checks = 0;
  int errors = 0;
  int snap;

  fc_scheduler #(.FEAT_N(FEAT_N), .NUM_CLASS(NUM_CLASS), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .maxpool_valid(maxpool_valid),
    .maxpool_bit(maxpool_bit), .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
    .fc_bias(fc_bias), .fc_result(fc_result), .fc_result_valid(fc_result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // weight ROM: data for the strobed address appears one cycle later
  always @(posedge clk) begin
    if (w_rd) begin
      w_data <= weightWord;
      wrdCount <= wrdCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkScores(input string tag, input logic [NUM_CLASS-1:0] posMask,
                             input int expPos, input int expNeg, input int bias0);
    for (int k = 0; k < NUM_CLASS; k++) begin
      int obs;
      int exp;
      logic signed [ACC_W-1:0] slice;
      slice = fc_result[k*ACC_W +: ACC_W];
      obs = int'(slice);
      exp = (posMask[k] ? expPos : expNeg) + ((k == 0) ? bias0 : 0);
      checkOutput($sformatf("%s class%0d", tag, k), obs, exp);
    end
  endtask

  task automatic pulseStart(input logic withValid);
    @(negedge clk);
    start = 1'b1;
    maxpool_valid = withValid;
    maxpool_bit = 1'b1;
    @(negedge clk);
    start = 1'b0;
    maxpool_valid = 1'b0;
  endtask

  // mode 0: all ones, mode 1: 1,0,1,0...; maxGap 0 gives back-to-back features
  task automatic applyStimulus(input int n, input int mode, input int maxGap);
    for (int i = 0; i < n; i++) begin
      int gap;
      @(negedge clk);
      maxpool_valid = 1'b1;
      maxpool_bit = (mode == 0) ? 1'b1 : ~i[0];
      gap = (i < n - 1) ? int'($urandom_range(maxGap, 0)) : 0;
      if (gap > 0) begin
        @(negedge clk);
        maxpool_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    maxpool_valid = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    checkOutput({tag, " valid after last accept"}, int'(fc_result_valid), 0);
    checkOutput({tag, " busy in drain"}, int'(busy), 1);
    @(negedge clk);
    checkOutput({tag, " valid one edge later"}, int'(fc_result_valid), 0);
    checkOutput({tag, " busy in done"}, int'(busy), 0);
    @(negedge clk);
    checkOutput({tag, " valid two edges later"}, int'(fc_result_valid), 1);
  endtask

  initial begin
    rstn = 1'b0;
    start = 1'b0;
    maxpool_valid = 1'b0;
    maxpool_bit = 1'b0;
    fc_bias = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset valid", int'(fc_result_valid), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset w_rd", int'(w_rd), 0);
    checkOutput("reset w_addr", int'(w_addr), 0);
    checkOutput("reset result zero", int'(fc_result == '0), 1);
    rstn = 1'b1;

    maxpool_valid = 1'b1;
    #1 checkOutput("idle w_rd", int'(w_rd), 0);
    @(negedge clk);
    maxpool_valid = 1'b0;

    $display("[TB] all-match image");
    weightWord = '1;
    pulseStart(1'b0);
    checkOutput("start busy", int'(busy), 1);
    snap = wrdCount;
    applyStimulus(FEAT_N, 0, 0);
    waitDone("allmatch");
    checkScores("allmatch", '1, 144, -144, 0);
    checkOutput("allmatch w_rd count", wrdCount - snap, FEAT_N);

    $display("[TB] class-3 weights");
    weightWord = 10'b0000001000;
    pulseStart(1'b0);
    checkOutput("restart clears valid", int'(fc_result_valid), 0);
    applyStimulus(FEAT_N, 0, 0);
    waitDone("class3");
    checkScores("class3", 10'b0000001000, 144, -144, 0);

    $display("[TB] alternating features");
    weightWord = '1;
    pulseStart(1'b0);
    applyStimulus(FEAT_N, 1, 0);
    waitDone("alt");
    checkScores("alt", '1, 0, 0, 0);
    pulseStart(1'b0);
    applyStimulus(FEAT_N, 1, 5);
    waitDone("altgap");
    checkScores("altgap", '1, 0, 0, 0);

    $display("[TB] abort and overfeed");
    weightWord = '0;
    pulseStart(1'b0);
    applyStimulus(50, 0, 0);
    weightWord = '1;
    pulseStart(1'b1);
    snap = wrdCount;
    applyStimulus(150, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("abort valid", int'(fc_result_valid), 1);
    checkScores("abort", '1, 144, -144, 0);
    checkOutput("overfeed w_rd count", wrdCount - snap, FEAT_N);
    maxpool_valid = 1'b1;
    #1 checkOutput("done w_rd", int'(w_rd), 0);
    @(negedge clk);
    maxpool_valid = 1'b0;

    $display("[TB] reset mid-image");
    weightWord = '0;
    pulseStart(1'b0);
    applyStimulus(70, 0, 0);
    rstn = 1'b0;
    #1;
    checkOutput("midreset valid", int'(fc_result_valid), 0);
    checkOutput("midreset busy", int'(busy), 0);
    checkOutput("midreset w_addr", int'(w_addr), 0);
    checkOutput("midreset result zero", int'(fc_result == '0), 1);
    @(negedge clk);
    rstn = 1'b1;
    weightWord = 10'b1010101010;
    pulseStart(1'b0);
    applyStimulus(FEAT_N, 0, 2);
    waitDone("postreset");
    checkScores("postreset", 10'b1010101010, 144, -144, 0);

    $display("[TB] bias image");
    fc_bias = '0;
    fc_bias[ACC_W-1:0] = ACC_W'(5);
    weightWord = '1;
    pulseStart(1'b0);
    applyStimulus(FEAT_N, 0, 0);
    waitDone("bias");
    checkScores("bias", '1, 144, -144, BIAS0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
